// File: rtl/pixel_block_compressor_if.sv
// Streaming bus for the pixel block compressor: pixel input handshake,
// beat output handshake, and the registered block header fields.
interface pixel_block_compressor_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_W       = 8
) ();
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_CHANNELS*CHAN_W-1:0] in_pixel;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_hdr;
  logic [NUM_CHANNELS*CHAN_W-1:0] out_data;
  logic [NUM_CHANNELS-1:0]        hdr_skip;
  logic [NUM_CHANNELS*CHAN_W-1:0] hdr_min;
  logic                           hdr_compressable;
  logic                           busy;

  // Compressor side.
  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_hdr, out_data,
           hdr_skip, hdr_min, hdr_compressable, busy
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_hdr, out_data,
           hdr_skip, hdr_min, hdr_compressable, busy
  );
endinterface

// File: rtl/pixel_block_compressor.sv
// Pixel block compressor: buffers NUM_PIXELS pixels while tracking the
// per-channel min/max, then emits a header beat followed by either
// per-channel residuals (pixel - min) or the raw pixels.
//
// Handshake: a beat moves on a rising edge only when valid and ready are
// both high; valid never depends on ready, and a presented beat holds
// stable until it is taken.
module pixel_block_compressor #(
  parameter int NUM_PIXELS   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_W       = 8,
  parameter int RES_W        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  pixel_block_compressor_if.slave   bus,
  output logic [1:0]                state_dbg
);
  localparam int CNT_W = $clog2(NUM_PIXELS);
  localparam int PIX_W = NUM_CHANNELS * CHAN_W;
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CHAN_W-1:0] RES_MAX = CHAN_W'((1 << RES_W) - 1);

  typedef enum logic [1:0] {FILL, HDR, EMIT} state_t;
  typedef logic [NUM_CHANNELS-1:0][CHAN_W-1:0] lanes_t;

  state_t state, state_next;
  logic armed;
  logic [CNT_W-1:0] pix_cnt, emit_cnt;
  logic [PIX_W-1:0] buffer [NUM_PIXELS];
  lanes_t run_min, run_max, nxt_min, nxt_max;
  lanes_t in_lanes, emit_pix, out_lanes, hdr_min;
  logic [NUM_CHANNELS-1:0] hdr_skip, skip_next;
  logic hdr_compressable, comp_next;
  logic [CHAN_W-1:0] diff;
  logic in_fire, out_fire, last_in, last_out;

  assign in_lanes  = bus.in_pixel;
  assign emit_pix  = buffer[emit_cnt];
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_in   = in_fire && (pix_cnt == LAST);
  assign last_out  = out_fire && (state == EMIT) && (emit_cnt == LAST);

  // armed holds in_ready low through reset and for the first edge after it.
  assign bus.in_ready         = (state == FILL) && armed;
  assign bus.out_valid        = (state != FILL);
  assign bus.busy             = (state != FILL);
  assign bus.out_hdr          = (state == HDR);
  assign bus.out_data         = out_lanes;
  assign bus.hdr_skip         = hdr_skip;
  assign bus.hdr_min          = hdr_min;
  assign bus.hdr_compressable = hdr_compressable;
  assign state_dbg            = state;

  // Running min/max including the pixel being accepted this cycle.
  always_comb begin
    nxt_min = run_min;
    nxt_max = run_max;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (pix_cnt == '0) begin
        nxt_min[c] = in_lanes[c];
        nxt_max[c] = in_lanes[c];
      end else begin
        if (in_lanes[c] < run_min[c]) nxt_min[c] = in_lanes[c];
        if (in_lanes[c] > run_max[c]) nxt_max[c] = in_lanes[c];
      end
    end
  end

  // Header fields derived from the completed block's min/max.
  always_comb begin
    comp_next = 1'b1;
    skip_next = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      skip_next[c] = (nxt_max[c] == nxt_min[c]);
      if ((nxt_max[c] - nxt_min[c]) > RES_MAX) comp_next = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_in)  state_next = HDR;
      HDR:     if (out_fire) state_next = EMIT;
      EMIT:    if (last_out) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Counters, running statistics and the registered header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed            <= 1'b0;
      pix_cnt          <= '0;
      emit_cnt         <= '0;
      run_min          <= '0;
      run_max          <= '0;
      hdr_min          <= '0;
      hdr_skip         <= '0;
      hdr_compressable <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        FILL: if (in_fire) begin
          pix_cnt <= pix_cnt + CNT_W'(1);
          run_min <= nxt_min;
          run_max <= nxt_max;
          if (pix_cnt == LAST) begin
            hdr_min          <= nxt_min;
            hdr_skip         <= skip_next;
            hdr_compressable <= comp_next;
          end
        end
        HDR: if (out_fire) emit_cnt <= '0;
        EMIT: if (out_fire) begin
          emit_cnt <= emit_cnt + CNT_W'(1);
          if (emit_cnt == LAST) pix_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Pixel buffer; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (in_fire) buffer[pix_cnt] <= bus.in_pixel;
  end

  // Output beat: header min in HDR, residual or raw pixel in EMIT.
  always_comb begin
    out_lanes = '0;
    diff      = '0;
    case (state)
      HDR: out_lanes = hdr_min;
      EMIT: begin
        if (hdr_compressable) begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            diff = emit_pix[c] - hdr_min[c];
            if (!hdr_skip[c])
              out_lanes[c] = {{(CHAN_W-RES_W){1'b0}}, diff[RES_W-1:0]};
          end
        end else begin
          out_lanes = emit_pix;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: doc/pixel_block_compressor.md
PIXEL_BLOCK_COMPRESSOR -- requirements
Module: pixel_block_compressor

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 32, pixels per block (>=2).
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 4, channels per pixel (>=1).
REQ-003 The block SHALL have parameter CHAN_W, default 8, bits per channel.
REQ-004 The block SHALL have parameter RES_W, default 4, residual bits per channel (1..CHAN_W-1).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, input pixel valid.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts the input pixel.
REQ-009 The block SHALL have port in_pixel, input, NUM_CHANNELS*CHAN_W, one pixel with channel 0 in the LSBs.
REQ-010 The block SHALL have port out_valid, output, 1, output beat valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the output beat.
REQ-012 The block SHALL have port out_hdr, output, 1, current beat is the header beat.
REQ-013 The block SHALL have port out_data, output, NUM_CHANNELS*CHAN_W, header or pixel or residual beat.
REQ-014 The block SHALL have port hdr_skip, output, NUM_CHANNELS, per-channel skip flags.
REQ-015 The block SHALL have port hdr_min, output, NUM_CHANNELS*CHAN_W, per-channel minimum values.
REQ-016 The block SHALL have port hdr_compressable, output, 1, block is emitted as residuals.
REQ-017 The block SHALL have port busy, output, 1, high in HDR or EMIT.

Function
REQ-018 Each handshake SHALL transfer a beat only on a cycle where valid and ready are both high.
REQ-019 The FSM SHALL have states FILL, HDR and EMIT.
REQ-020 in_ready SHALL be 1 only in FILL.
REQ-021 out_valid SHALL be 1 only in HDR or EMIT.
REQ-022 In FILL, each accepted pixel SHALL be stored at buffer index pix_cnt, and pix_cnt SHALL increment.
REQ-023 In FILL, the first accepted pixel of a block SHALL load the running min and max of every channel.
REQ-024 In FILL, each later accepted pixel SHALL update the running min and max with unsigned compares.
REQ-025 The FSM SHALL go FILL->HDR on the cycle after the NUM_PIXELS-th pixel is accepted.
REQ-026 The header beat SHALL be presented with one cycle latency from the last input acceptance.
REQ-027 On entry to HDR, the header SHALL be registered as follows:
  - hdr_min = per-channel min;
  - hdr_skip[c] = (max_c == min_c);
  - hdr_compressable = 1 iff max_c - min_c <= 2^RES_W - 1 for every c.
REQ-028 The header fields SHALL be held stable through HDR and EMIT.
REQ-029 In HDR, out_hdr SHALL be 1 and out_data SHALL equal hdr_min.
REQ-030 On header acceptance the FSM SHALL go HDR->EMIT with emit_cnt = 0.
REQ-031 In EMIT, out_hdr SHALL be 0 and out_data SHALL be derived from buffer[emit_cnt].
REQ-032 In EMIT with hdr_compressable = 1, each lane c of out_data SHALL be:
  - pixel_c - min_c in the low RES_W bits with the upper bits zero;
  - zero in its entirety when hdr_skip[c] = 1.
REQ-033 In EMIT with hdr_compressable = 0, out_data SHALL be the raw buffered pixel, unchanged.
REQ-034 Each accepted EMIT beat SHALL increment emit_cnt.
REQ-035 On acceptance of beat NUM_PIXELS-1 the FSM SHALL go EMIT->FILL with pix_cnt = 0.
REQ-036 The next block's input SHALL NOT be accepted in the same cycle as the last output beat.
REQ-037 While out_valid = 1 and out_ready = 0, out_data, out_hdr and the header fields SHALL hold.
REQ-038 Back-pressure SHALL NOT drop, duplicate or reorder any beat.
REQ-039 A pixel with in_valid = 1 while in_ready = 0 SHALL be ignored, and in_pixel SHALL not affect state.
REQ-040 Residual subtraction SHALL never underflow, since min_c <= pixel_c by construction.
REQ-041 Counters SHALL be $clog2(NUM_PIXELS) bits wide, with wrap handled by state transition rather than overflow.

Reset
REQ-042 While rst = 1, the block SHALL force state = FILL, pix_cnt = 0 and emit_cnt = 0.
REQ-043 While rst = 1, the block SHALL force out_valid = 0, out_hdr = 0, out_data = 0, busy = 0 and in_ready = 0.
REQ-044 While rst = 1, the block SHALL force hdr_skip = 0, hdr_min = 0, hdr_compressable = 0 and the running min/max to 0.
REQ-045 On the first clock edge after rst deasserts, in_ready SHALL rise to 1.
REQ-046 Buffer contents need not be reset.
REQ-047 Reset mid-block SHALL discard the partial block, whether in FILL, HDR or EMIT.
REQ-048 After reset, no partial header or residual beat SHALL appear.

Verification (defaults)
REQ-049 32 pixels all 0x10203040 -> must produce:
  - header: hdr_skip = 4'b1111, hdr_min = 0x10203040, hdr_compressable = 1;
  - 32 EMIT beats of 0x00000000.
REQ-050 Channel 0 ramps 100..131, other channels constant 7 -> must produce:
  - header: hdr_compressable = 0 (delta 31 > 15), hdr_skip = 4'b1110;
  - 32 raw pixels returned unchanged in order.
REQ-051 Channel 0 = 200..215 twice, others 0 -> must produce:
  - header: hdr_min[7:0] = 200, hdr_compressable = 1;
  - lane 0 residuals 0..15, 0..15; lanes 1-3 zero.
REQ-052 out_ready low for 5 cycles after EMIT beat 3 -> out_data must hold beat 4's value, 32 beats must total, and in_ready must stay 0.
REQ-053 rst pulse after 10 input beats, then 32 fresh pixels of 0x01010101 -> hdr_min must be 0x01010101, with no influence from the first 10.
REQ-054 in_valid held high through HDR/EMIT -> no pixel may be accepted until FILL, and the next block's first pixel must be the one present on the first in_ready = 1 cycle.
